// File: rtl/rom_fetch_arbiter.sv
// rom_fetch_arbiter
//
// Shares one byte-wide ROM that reads combinationally between two requesters:
// instruction fetch (IF) and load (LS). Each granted request becomes four
// consecutive byte reads. The four bytes are assembled into a big-endian word,
// so the lowest address lands in bits [31:24].
//
// Handshake: a requester raises *_req and holds *_addr stable. The arbiter
// latches the word-aligned address when it grants the request. Four cycles
// later it returns *_ready as a single-cycle pulse, and *_data is valid in that
// same cycle. A req that is still high when the arbiter is back in IDLE counts
// as a new request. A req that drops mid-transaction does not abort it.
//
// Ports:
//   clk, rst           clock and synchronous active-high reset
//   if_req/if_addr     IF request and byte address (bits [1:0] ignored)
//   if_ready/if_data   IF completion pulse and last word returned to IF
//   ls_req/ls_addr     LS request and byte address (bits [1:0] ignored)
//   ls_ready/ls_data   LS completion pulse and last word returned to LS
//   rom_en/rom_addr    ROM byte read strobe and masked byte address
//   rom_byte           ROM read data, valid in the same cycle as rom_addr
//   busy               high whenever the arbiter is not IDLE
//   dbg_state          current FSM state (0 IDLE, 1 READ, 2 DONE)
module rom_fetch_arbiter #(
  parameter int unsigned            ADDR_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0]  ADDR_MASK  = 32'h000fffff
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  if_req,
  input  logic [ADDR_WIDTH-1:0] if_addr,
  output logic                  if_ready,
  output logic [31:0]           if_data,
  input  logic                  ls_req,
  input  logic [ADDR_WIDTH-1:0] ls_addr,
  output logic                  ls_ready,
  output logic [31:0]           ls_data,
  output logic                  rom_en,
  output logic [ADDR_WIDTH-1:0] rom_addr,
  input  logic [7:0]            rom_byte,
  output logic                  busy,
  output logic [1:0]            dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_READ = 2'd1,
    S_DONE = 2'd2
  } state_t;

  // Owner / last_grant encoding
  localparam logic OWN_IF = 1'b0;
  localparam logic OWN_LS = 1'b1;

  state_t                state_q, state_d;
  logic [1:0]            cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0] base_q, base_d;
  logic                  owner_q, owner_d;
  logic                  last_grant_q, last_grant_d;
  logic [31:0]           shift_q, shift_d;
  logic [31:0]           if_data_q, if_data_d;
  logic [31:0]           ls_data_q, ls_data_d;
  logic                  if_ready_q, if_ready_d;
  logic                  ls_ready_q, ls_ready_d;

  logic                  winner;
  logic [ADDR_WIDTH-1:0] win_addr;

  // On a tie the requester that was not served last wins. Otherwise the only
  // active requester wins.
  assign winner   = (if_req && ls_req) ? ~last_grant_q : ls_req;
  assign win_addr = (winner == OWN_LS) ? ls_addr : if_addr;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    base_d       = base_q;
    owner_d      = owner_q;
    last_grant_d = last_grant_q;
    shift_d      = shift_q;
    if_data_d    = if_data_q;
    ls_data_d    = ls_data_q;
    if_ready_d   = 1'b0;
    ls_ready_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (if_req || ls_req) begin
          owner_d      = winner;
          last_grant_d = winner;
          base_d       = {win_addr[ADDR_WIDTH-1:2], 2'b00};
          cnt_d        = 2'd0;
          state_d      = S_READ;
        end
      end
      S_READ: begin
        shift_d = {shift_q[23:0], rom_byte};
        cnt_d   = cnt_q + 2'd1;
        if (cnt_q == 2'd3) begin
          state_d = S_DONE;
          // Ready is registered so that it is high exactly during DONE.
          if_ready_d = (owner_q == OWN_IF);
          ls_ready_d = (owner_q == OWN_LS);
        end
      end
      S_DONE: begin
        if (owner_q == OWN_LS) ls_data_d = shift_q;
        else                   if_data_d = shift_q;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      cnt_q        <= 2'd0;
      base_q       <= '0;
      owner_q      <= OWN_IF;
      last_grant_q <= OWN_IF;
      shift_q      <= 32'd0;
      if_data_q    <= 32'd0;
      ls_data_q    <= 32'd0;
      if_ready_q   <= 1'b0;
      ls_ready_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      base_q       <= base_d;
      owner_q      <= owner_d;
      last_grant_q <= last_grant_d;
      shift_q      <= shift_d;
      if_data_q    <= if_data_d;
      ls_data_q    <= ls_data_d;
      if_ready_q   <= if_ready_d;
      ls_ready_q   <= ls_ready_d;
    end
  end

  // In DONE the owner sees the freshly assembled word at once. The data
  // register only captures it at the end of that cycle.
  assign if_data  = (state_q == S_DONE && owner_q == OWN_IF) ? shift_q : if_data_q;
  assign ls_data  = (state_q == S_DONE && owner_q == OWN_LS) ? shift_q : ls_data_q;
  assign if_ready = if_ready_q;
  assign ls_ready = ls_ready_q;

  // The mask is applied after the 32-bit add, so a carry out of masked bits
  // is dropped.
  assign rom_en   = (state_q == S_READ);
  assign rom_addr = rom_en ? ((base_q + {{(ADDR_WIDTH-2){1'b0}}, cnt_q}) & ADDR_MASK)
                           : '0;
  assign busy      = (state_q != S_IDLE);
  assign dbg_state = state_q;

  // Byte-offset bits of the request addresses are intentionally ignored.
  logic unused_addr_lsbs;
  assign unused_addr_lsbs = ^{if_addr[1:0], ls_addr[1:0]};

endmodule

// File: tb/tb_rom_fetch_arbiter.sv
module tb_rom_fetch_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req, ls_req;
  logic [31:0] if_addr, ls_addr;
  logic        if_ready, ls_ready;
  logic [31:0] if_data, ls_data;
  logic        rom_en;
  logic [31:0] rom_addr;
  logic [7:0]  rom_byte;
  logic        busy;
  logic [1:0]  dbg_state;

  logic [7:0]  rom_mem [0:4095];

  int          n_pass  = 0;
  int          n_total = 0;
  logic [31:0] exp_if_q [$];
  logic [31:0] exp_ls_q [$];
  logic [31:0] held_if, held_ls;

  typedef struct {
    bit          ls;
    logic [31:0] addr;
    logic [31:0] rom0;
    logic [31:0] word;
  } vec_t;
  vec_t vecs [8];

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  rom_fetch_arbiter dut (
    .clk       (clk),
    .rst       (rst),
    .if_req    (if_req),
    .if_addr   (if_addr),
    .if_ready  (if_ready),
    .if_data   (if_data),
    .ls_req    (ls_req),
    .ls_addr   (ls_addr),
    .ls_ready  (ls_ready),
    .ls_data   (ls_data),
    .rom_en    (rom_en),
    .rom_addr  (rom_addr),
    .rom_byte  (rom_byte),
    .busy      (busy),
    .dbg_state (dbg_state)
  );

  // ROM model: combinational read
  assign rom_byte = rom_mem[rom_addr[11:0]];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Advance to just after the next rising edge; that point is "the cycle".
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    if_req = 1'b0; ls_req = 1'b0;
    if_addr = 32'd0; ls_addr = 32'd0;
    tick();
    tick();
    chk("reset if_data", if_data, 32'd0);
    chk("reset ls_data", ls_data, 32'd0);
    chk("reset if_ready", 32'(if_ready), 32'd0);
    chk("reset ls_ready", 32'(ls_ready), 32'd0);
    chk("reset busy", 32'(busy), 32'd0);
    chk("reset rom_en", 32'(rom_en), 32'd0);
    chk("reset rom_addr", rom_addr, 32'd0);
    rst = 1'b0;
    held_if = 32'd0;
    held_ls = 32'd0;
    exp_if_q.delete();
    exp_ls_q.delete();
  endtask

  // Drive one request in the current cycle and follow it to completion.
  // hold=0 drops req after one cycle. In-flight addresses are scrambled to
  // show that the base address is latched.
  task automatic run_txn(input string tag, input bit ls, input logic [31:0] addr,
                         input logic [31:0] rom0, input logic [31:0] word, input bit hold);
    logic [31:0] exp_w;
    logic        own_rdy, oth_rdy;
    logic [31:0] own_dat, oth_dat, oth_held;
    if (ls) begin ls_req = 1'b1; ls_addr = addr; exp_ls_q.push_back(word); end
    else    begin if_req = 1'b1; if_addr = addr; exp_if_q.push_back(word); end
    for (int c = 1; c <= 5; c++) begin
      tick();
      if (c == 1 && !hold) begin
        if (ls) ls_req = 1'b0; else if_req = 1'b0;
      end
      if (c == 2) begin
        if (ls) ls_addr = 32'h0000_0ffc; else if_addr = 32'h0000_0ffc;
      end
      own_rdy  = ls ? ls_ready : if_ready;
      oth_rdy  = ls ? if_ready : ls_ready;
      own_dat  = ls ? ls_data : if_data;
      oth_dat  = ls ? if_data : ls_data;
      oth_held = ls ? held_if : held_ls;
      chk($sformatf("%s c%0d busy", tag, c), 32'(busy), 32'd1);
      chk($sformatf("%s c%0d rom_en", tag, c), 32'(rom_en), (c < 5) ? 32'd1 : 32'd0);
      chk($sformatf("%s c%0d rom_addr", tag, c), rom_addr, (c < 5) ? rom0 + 32'(c - 1) : 32'd0);
      chk($sformatf("%s c%0d owner ready", tag, c), 32'(own_rdy), (c == 5) ? 32'd1 : 32'd0);
      chk($sformatf("%s c%0d other ready", tag, c), 32'(oth_rdy), 32'd0);
      chk($sformatf("%s c%0d other data held", tag, c), oth_dat, oth_held);
      if (c == 5) begin
        exp_w = ls ? exp_ls_q.pop_front() : exp_if_q.pop_front();
        chk($sformatf("%s data", tag), own_dat, exp_w);
        if (ls) begin held_ls = exp_w; ls_req = 1'b0; ls_addr = 32'd0; end
        else    begin held_if = exp_w; if_req = 1'b0; if_addr = 32'd0; end
      end
    end
    tick();
    chk($sformatf("%s idle busy", tag), 32'(busy), 32'd0);
    chk($sformatf("%s idle rom_en", tag), 32'(rom_en), 32'd0);
    chk($sformatf("%s idle readies", tag), {30'd0, if_ready, ls_ready}, 32'd0);
    chk($sformatf("%s idle if_data", tag), if_data, held_if);
    chk($sformatf("%s idle ls_data", tag), ls_data, held_ls);
  endtask

  initial begin
    logic [31:0] exp_w;
    bit          e_ls, e_if;

    for (int i = 0; i < 4096; i++) rom_mem[i] = 8'(i * 7 + 3);
    {rom_mem[12'h000], rom_mem[12'h001], rom_mem[12'h002], rom_mem[12'h003]} = 32'h12345678;
    {rom_mem[12'h004], rom_mem[12'h005], rom_mem[12'h006], rom_mem[12'h007]} = 32'hAABBCCDD;
    {rom_mem[12'h100], rom_mem[12'h101], rom_mem[12'h102], rom_mem[12'h103]} = 32'hDEADBEEF;
    {rom_mem[12'h200], rom_mem[12'h201], rom_mem[12'h202], rom_mem[12'h203]} = 32'h01020304;
    {rom_mem[12'h204], rom_mem[12'h205], rom_mem[12'h206], rom_mem[12'h207]} = 32'h55667788;
    {rom_mem[12'hffc], rom_mem[12'hffd], rom_mem[12'hffe], rom_mem[12'hfff]} = 32'hF0E1D2C3;

    vecs[0] = '{ls: 1'b0, addr: 32'h0000_0000, rom0: 32'h0000_0000, word: 32'h12345678};
    vecs[1] = '{ls: 1'b1, addr: 32'h0000_0004, rom0: 32'h0000_0004, word: 32'hAABBCCDD};
    vecs[2] = '{ls: 1'b1, addr: 32'h0010_0103, rom0: 32'h0000_0100, word: 32'hDEADBEEF};
    vecs[3] = '{ls: 1'b0, addr: 32'h0000_0207, rom0: 32'h0000_0204, word: 32'h55667788};
    vecs[4] = '{ls: 1'b0, addr: 32'h0010_0002, rom0: 32'h0000_0000, word: 32'h12345678};
    vecs[5] = '{ls: 1'b1, addr: 32'h0000_0200, rom0: 32'h0000_0200, word: 32'h01020304};
    vecs[6] = '{ls: 1'b1, addr: 32'h0ff0_0ffe, rom0: 32'h0000_0ffc, word: 32'hF0E1D2C3};
    vecs[7] = '{ls: 1'b0, addr: 32'hffff_ffff, rom0: 32'h000f_fffc, word: 32'hF0E1D2C3};

    do_reset();

    // Tie right after reset: both requests held, grants alternate LS, IF, LS, IF.
    if_req = 1'b1; if_addr = 32'h0;
    ls_req = 1'b1; ls_addr = 32'h4;
    exp_ls_q.push_back(32'hAABBCCDD); exp_ls_q.push_back(32'hAABBCCDD);
    exp_if_q.push_back(32'h12345678); exp_if_q.push_back(32'h12345678);
    for (int c = 1; c <= 23; c++) begin
      tick();
      e_ls = (c == 5) || (c == 17);
      e_if = (c == 11) || (c == 23);
      chk($sformatf("tie c%0d ls_ready", c), 32'(ls_ready), 32'(e_ls));
      chk($sformatf("tie c%0d if_ready", c), 32'(if_ready), 32'(e_if));
      chk($sformatf("tie c%0d busy", c), 32'(busy), (c % 6 == 0) ? 32'd0 : 32'd1);
      if (e_ls) begin
        exp_w = exp_ls_q.pop_front();
        chk($sformatf("tie c%0d ls_data", c), ls_data, exp_w);
        held_ls = exp_w;
      end
      if (e_if) begin
        exp_w = exp_if_q.pop_front();
        chk($sformatf("tie c%0d if_data", c), if_data, exp_w);
        held_if = exp_w;
      end
      if (c == 23) begin if_req = 1'b0; ls_req = 1'b0; end
    end
    tick();
    chk("tie end busy", 32'(busy), 32'd0);

    // Table-driven single transactions, back to back.
    for (int i = 0; i < 8; i++)
      run_txn($sformatf("vec%0d", i), vecs[i].ls, vecs[i].addr, vecs[i].rom0, vecs[i].word, 1'b1);

    // LS request held for one cycle only: the transaction still completes.
    run_txn("drop", 1'b1, 32'h0000_0100, 32'h0000_0100, 32'hDEADBEEF, 1'b0);
    for (int c = 0; c < 4; c++) begin
      tick();
      chk($sformatf("drop after c%0d rom_en", c), 32'(rom_en), 32'd0);
      chk($sformatf("drop after c%0d busy", c), 32'(busy), 32'd0);
    end

    // Reset in the middle of an IF transaction.
    if_req = 1'b1; if_addr = 32'h0000_0200;
    tick();
    tick();
    chk("rstmid c2 rom_addr", rom_addr, 32'h0000_0201);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    if_req = 1'b0; if_addr = 32'd0;
    held_if = 32'd0; held_ls = 32'd0;
    chk("rstmid c4 rom_en", 32'(rom_en), 32'd0);
    chk("rstmid c4 busy", 32'(busy), 32'd0);
    chk("rstmid c4 if_ready", 32'(if_ready), 32'd0);
    chk("rstmid c4 if_data", if_data, 32'd0);
    chk("rstmid c4 ls_data", ls_data, 32'd0);
    tick();
    run_txn("rstmid fresh", 1'b0, 32'h0000_0000, 32'h0000_0000, 32'h12345678, 1'b1);

    chk("scoreboard if queue empty", 32'(exp_if_q.size()), 32'd0);
    chk("scoreboard ls queue empty", 32'(exp_ls_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/rom_fetch_arbiter.md
Name: rom_fetch_arbiter

Overview:
Shares one byte-wide, combinational-read instruction/data ROM between two requesters: instruction fetch (IF) and load (LS). Each granted request is turned into four consecutive byte reads. The four bytes are assembled into a big-endian 32-bit word: the byte at the lowest address lands in bits [31:24]. The block sits between the CPU fetch/memory stages and the simulation ROM model, and replaces direct dual-port ROM access.

Parameters:
ADDR_WIDTH, 32, width of all address ports
ADDR_MASK, 32'h000fffff, mask applied to every ROM byte address driven out

Ports:
clk  input  1  clock; all state updates on rising edge
rst  input  1  synchronous reset, active-high
if_req  input  1  IF request; held with if_addr stable until if_ready
if_addr  input  32  IF byte address; bits [1:0] ignored
if_ready  output  1  one-cycle pulse; if_data valid this cycle
if_data  output  32  last word returned to IF
ls_req  input  1  LS request; same rules as if_req
ls_addr  input  32  LS byte address; bits [1:0] ignored
ls_ready  output  1  one-cycle pulse; ls_data valid this cycle
ls_data  output  32  last word returned to LS
rom_en  output  1  ROM byte read enable
rom_addr  output  32  ROM byte address
rom_byte  input  8  ROM read data, combinational from rom_addr in the same cycle
busy  output  1  high whenever state != IDLE

Behaviour:
- States: IDLE, READ, DONE. Internal registers:
  - cnt: 2-bit byte counter
  - base: 32-bit word address
  - owner: 1-bit, IF or LS
  - last_grant: 1-bit
  - shift: 32-bit assembly register
- Reset (rst=1 at a clock edge), including in the middle of a transaction:
  - state=IDLE, cnt=0, base=0, shift=0.
  - if_data=0, ls_data=0, if_ready=0, ls_ready=0.
  - last_grant=IF, so LS wins the first tie after reset.
  - Any in-flight transaction is dropped; no ready pulse is ever produced for it.
- IDLE:
  - Only ls_req: grant LS.
  - Only if_req: grant IF.
  - Both: grant the requester that is not last_grant.
  - On grant: owner <= winner, last_grant <= winner, base <= {addr[31:2],2'b00}, cnt <= 0, next state READ.
  - No request: stay in IDLE.
- READ, exactly 4 cycles:
  - rom_en=1, rom_addr=(base + cnt) & ADDR_MASK.
  - Each cycle: shift <= {shift[23:0], rom_byte}, cnt <= cnt+1.
  - After cnt==3, next state DONE.
- DONE, 1 cycle:
  - The owner's ready=1 and its data register is loaded from shift.
  - The data output reflects the new word in that same cycle, i.e. data is driven combinationally from shift while in DONE, then held.
  - Next state IDLE.
- Latency: request sampled in IDLE at cycle N → rom reads in cycles N+1..N+4 → ready in cycle N+5. Earliest next grant is at cycle N+6; throughput is one word per 6 cycles.
- Outside READ: rom_en=0, rom_addr=0.
- The non-owner's ready is always 0; its data output holds its last value.
- Requester protocol:
  - Drop req in the ready cycle or the cycle after; req still high in IDLE counts as a new request.
  - Address changes while a transaction is in flight have no effect (base is latched).
- req deasserted mid-transaction: the transaction still completes and ready still pulses (no abort).
- A new request arriving while busy waits; it is not queued beyond the level-held req.
- Address arithmetic is 32-bit and the mask is applied after the add. Example: base 0x0010_0000 gives rom_addr 0x0000_0000..0x0000_0003.
- busy=1 in READ and DONE, 0 in IDLE.

Test Plan:
- Single IF fetch: ROM[0..3]=12 34 56 78, if_req with if_addr=0x0 at cycle 0 → rom_addr 0,1,2,3 on cycles 1-4; if_ready=1 and if_data=0x12345678 at cycle 5 only; ls_ready stays 0.
- Tie right after reset: if_req and ls_req both held, ls_addr=0x4 (bytes AA BB CC DD), if_addr=0x0 → ls_ready with 0xAABBCCDD at cycle 5, then if_ready with 0x12345678 at cycle 11. With both reqs continuously re-asserted, grants strictly alternate LS, IF, LS, IF.
- Unaligned and masked address: ls_addr=0x0010_0103 → rom_addr 0x100..0x103, ls_data equals the big-endian word at 0x100.
- Reset mid-operation: if_req at cycle 0, rst=1 at cycle 3 → rom_en=0 and busy=0 from cycle 4; no if_ready; if_data=0. A fresh request at cycle 5 returns its data at cycle 10.
- Request dropped mid-transaction: ls_req high cycle 0 only → ls_ready still pulses at cycle 5 with the correct word; the block then stays IDLE with rom_en=0.
- Held data: after an IF return of 0x12345678, an LS transaction completes → if_data still reads 0x12345678 throughout.
